adc_frame_packer: RTL and testbench

Downstream stage of the ADC trigger/capture block. It takes that block's 64-bit sample stream, which has no backpressure, and buffers it. It splits each trigger burst into length-limited frames, each prefixed with header words carrying the trigger value and time. It emits the frames on a backpressured AXI4-Stream master toward the DMA/writer.

---
 rtl/adc_pkt_pkg.sv | 40 ++++
 rtl/adc_pkt_fifo.sv | 47 ++++
 rtl/adc_frame_packer.sv | 224 ++++++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkt_pkg.sv
// Shared constants, FSM encoding and descriptor layout for the ADC frame packer.
// ADC_PACKER_TIMESTAMP_EN adds the HDR1 state and the time/drop fields of the descriptor.
package adc_pkt_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    localparam int FLAG_FIRST = 0;
    localparam int FLAG_LAST  = 1;
    localparam int FLAG_DROP  = 2;

    localparam int LEN_W   = 16;
    localparam int SEQ_W   = 16;
    localparam int TVAL_W  = 16;
    localparam int TTIME_W = 32;
    localparam int DROP_W  = 16;
    localparam int FLAGS_W = 3;

`ifdef ADC_PACKER_TIMESTAMP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_PAYLOAD} rd_state_t;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SEQ_W-1:0]   seq;
        logic [TVAL_W-1:0]  trig_value;
        logic [TTIME_W-1:0] trig_time;
        logic [DROP_W-1:0]  drop_snap;
        logic [FLAGS_W-1:0] flags;
    } desc_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HDR0, ST_PAYLOAD} rd_state_t;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SEQ_W-1:0]   seq;
        logic [TVAL_W-1:0]  trig_value;
        logic [FLAGS_W-1:0] flags;
    } desc_t;
`endif

endpackage

// File: rtl/adc_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is valid whenever empty is low.
// A write while full is accepted when a read happens in the same cycle.
module adc_pkt_fifo #(
    parameter int WIDTH = 64,
    parameter int AW    = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & ~clear & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Buffers the unstallable ADC sample stream and emits header-prefixed frames on AXI4-Stream.
// Define ADC_PACKER_TIMESTAMP_EN to add the HDR1 word (trigger time, drop snapshot, flags).
module adc_frame_packer
    import adc_pkt_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FRAME_LEN  = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic [15:0] trig_value,
    input  logic [31:0] trig_time,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] drop_count
);

    localparam logic [LEN_W-1:0] FRAME_LEN_W = LEN_W'(FRAME_LEN);
    localparam logic [LEN_W-1:0] FRAME_MAX_IDX = LEN_W'(FRAME_LEN - 1);

    logic              prev_tvalid, burst_start, fall_close, len_close, try_close;
    logic              accept, drop_now, push_en, close_pending, seg_first, drop_since;
    logic [LEN_W-1:0]  seg_count, pay_count;
    logic [SEQ_W-1:0]  seq;
    logic [TVAL_W-1:0] burst_tval;
    desc_t             new_desc, push_desc, pend_desc, desc_dout, cur_desc;
    logic              data_full, data_empty, desc_full, desc_empty;
    logic [63:0]       data_dout, load_data;
    logic              desc_rd, data_rd, load, load_last, out_ready, pay_last;
    rd_state_t         state, state_n;

`ifdef ADC_PACKER_TIMESTAMP_EN
    logic [TTIME_W-1:0] burst_ttime;
`else
    logic unused_bits;
    assign unused_bits = ^{trig_time, cur_desc.flags};
`endif

    adc_pkt_fifo #(.WIDTH(64), .AW(ADDR_WIDTH)) u_data_fifo (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .wr_en(accept), .wr_data(s_axis_tdata),
        .rd_en(data_rd), .rd_data(data_dout),
        .full(data_full), .empty(data_empty)
    );

    adc_pkt_fifo #(.WIDTH($bits(desc_t)), .AW(2)) u_desc_fifo (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .wr_en(push_en), .wr_data(push_desc),
        .rd_en(desc_rd), .rd_data(desc_dout),
        .full(desc_full), .empty(desc_empty)
    );

    // A close that finds the descriptor FIFO full is parked in pend_desc so a new burst
    // can still latch its own trigger values; seq and drop info are taken at push time.
    always_comb begin
        burst_start = s_axis_tvalid & ~prev_tvalid;
        fall_close  = ~s_axis_tvalid & prev_tvalid & (seg_count != '0);
        accept      = s_axis_tvalid & ~data_full & ~desc_full & ~close_pending;
        drop_now    = s_axis_tvalid & ~accept;
        len_close   = accept & (seg_count == FRAME_MAX_IDX);
        try_close   = fall_close | close_pending;
        push_en     = len_close | (try_close & ~desc_full);

        new_desc = '0;
        new_desc.len = len_close ? FRAME_LEN_W : seg_count;
        new_desc.trig_value = burst_start ? trig_value : burst_tval;
`ifdef ADC_PACKER_TIMESTAMP_EN
        new_desc.trig_time = burst_start ? trig_time : burst_ttime;
`endif
        new_desc.flags[FLAG_FIRST] = burst_start | seg_first;
        new_desc.flags[FLAG_LAST]  = fall_close;

        push_desc = close_pending ? pend_desc : new_desc;
        push_desc.seq = seq;
        push_desc.flags[FLAG_DROP] = drop_since;
`ifdef ADC_PACKER_TIMESTAMP_EN
        push_desc.drop_snap = drop_count;
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_tvalid   <= 1'b0;
            seg_count     <= '0;
            seg_first     <= 1'b0;
            close_pending <= 1'b0;
            pend_desc     <= '0;
            seq           <= '0;
            drop_count    <= '0;
            drop_since    <= 1'b0;
            burst_tval    <= '0;
`ifdef ADC_PACKER_TIMESTAMP_EN
            burst_ttime   <= '0;
`endif
        end else if (clear) begin
            prev_tvalid   <= 1'b0;
            seg_count     <= '0;
            seg_first     <= 1'b0;
            close_pending <= 1'b0;
            pend_desc     <= '0;
            seq           <= '0;
            drop_count    <= '0;
            drop_since    <= 1'b0;
            burst_tval    <= '0;
`ifdef ADC_PACKER_TIMESTAMP_EN
            burst_ttime   <= '0;
`endif
        end else begin
            prev_tvalid <= s_axis_tvalid;
            if (burst_start) begin
                burst_tval <= trig_value;
`ifdef ADC_PACKER_TIMESTAMP_EN
                burst_ttime <= trig_time;
`endif
            end
            if (len_close || fall_close) seg_count <= '0;
            else if (accept)             seg_count <= seg_count + 1'b1;
            if (len_close || fall_close) seg_first <= 1'b0;
            else if (burst_start)        seg_first <= 1'b1;
            if (fall_close && desc_full) pend_desc <= new_desc;
            close_pending <= try_close & desc_full;
            if (push_en) seq <= seq + 1'b1;
            if (drop_now && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            if (push_en)       drop_since <= drop_now;
            else if (drop_now) drop_since <= 1'b1;
        end
    end

    assign out_ready = ~m_axis_tvalid | m_axis_tready;
    assign pay_last  = (pay_count == cur_desc.len - 1'b1);

    // On the last payload word the next descriptor is popped directly so frames abut.
    always_comb begin
        state_n   = state;
        desc_rd   = 1'b0;
        data_rd   = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = '0;
        case (state)
            ST_IDLE: begin
                if (!desc_empty) begin
                    desc_rd = 1'b1;
                    state_n = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (out_ready) begin
                    load      = 1'b1;
                    load_data = {HDR_MAGIC, cur_desc.seq, cur_desc.trig_value, cur_desc.len};
`ifdef ADC_PACKER_TIMESTAMP_EN
                    state_n   = ST_HDR1;
`else
                    state_n   = ST_PAYLOAD;
`endif
                end
            end
`ifdef ADC_PACKER_TIMESTAMP_EN
            ST_HDR1: begin
                if (out_ready) begin
                    load      = 1'b1;
                    load_data = {cur_desc.trig_time, cur_desc.drop_snap, 8'h00,
                                 {(8-FLAGS_W){1'b0}}, cur_desc.flags};
                    state_n   = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (out_ready && !data_empty) begin
                    load      = 1'b1;
                    data_rd   = 1'b1;
                    load_data = data_dout;
                    if (pay_last) begin
                        load_last = 1'b1;
                        if (!desc_empty) begin
                            desc_rd = 1'b1;
                            state_n = ST_HDR0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            cur_desc      <= '0;
            pay_count     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (clear) begin
            state         <= ST_IDLE;
            cur_desc      <= '0;
            pay_count     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state <= state_n;
            if (desc_rd) begin
                cur_desc  <= desc_dout;
                pay_count <= '0;
            end else if (data_rd) begin
                pay_count <= pay_count + 1'b1;
            end
            if (out_ready) begin
                m_axis_tvalid <= load;
                m_axis_tlast  <= load & load_last;
                if (load) m_axis_tdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer (ADDR_WIDTH=10, FRAME_LEN=256).
// Header expectations follow ADC_PACKER_TIMESTAMP_EN when it is defined.
module tb_adc_frame_packer;

`ifdef ADC_PACKER_TIMESTAMP_EN
    localparam int HDRS = 2;
`else
    localparam int HDRS = 1;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [15:0] trig_value = '0;
    logic [31:0] trig_time = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] drop_count;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int stall_viol = 0;
    logic [64:0] cap_q[$];
    int          cyc_q[$];
    logic        prev_stall = 1'b0;
    logic [64:0] prev_word = '0;

    adc_frame_packer #(.ADDR_WIDTH(10), .FRAME_LEN(256)) dut (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .trig_value(trig_value), .trig_time(trig_time),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle <= cycle + 1;

    // Transfers and stall stability are observed on the falling edge; inputs move at posedge+1.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_word))
                stall_viol = stall_viol + 1;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_q.push_back({m_axis_tlast, m_axis_tdata});
                cyc_q.push_back(cycle);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [64:0] hdr0w(input logic [15:0] sq, input logic [15:0] tv,
                                          input logic [15:0] ln);
        return {1'b0, 16'hA55A, sq, tv, ln};
    endfunction

    function automatic logic [64:0] hdr1w(input logic [31:0] tt, input logic [15:0] dr,
                                          input logic [7:0] fl);
        return {1'b0, tt, dr, 8'h00, fl};
    endfunction

    task automatic drive_burst(input int n, input logic [31:0] tag, input logic [15:0] tv,
                               input logic [31:0] tt);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {tag, 32'(i)};
            trig_value    = (i == 0) ? tv : 16'hDEAD;
            trig_time     = (i == 0) ? tt : 32'hDEADBEEF;
        end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic do_clear();
        @(posedge aclk); #1;
        clear = 1'b1;
        @(posedge aclk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_words(input int base, input int n, input int budget, input string name);
        int k = 0;
        while (cap_q.size() < base + n && k < budget) begin
            @(negedge aclk);
            k++;
        end
        repeat (4) @(negedge aclk);
        total++;
        if (cap_q.size() != base + n) begin
            $display("[TB] FAIL %s word count: got=%0d want=%0d", name, cap_q.size() - base, n);
            bad++;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, drop_count} !== '0) begin
            $display("[TB] FAIL reset_in: got=%h want=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, drop_count});
            bad++;
        end
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            $display("[TB] FAIL reset_tvalid: got=%b want=0", m_axis_tvalid);
            bad++;
        end
        total++;
        if (drop_count !== 16'h0) begin
            $display("[TB] FAIL reset_drop: got=%h want=0", drop_count);
            bad++;
        end
    endtask

    task automatic test_short_burst();
        int base;
        logic [64:0] exp;
        base = cap_q.size();
        drive_burst(10, 32'h1, 16'h1234, 32'hCAFE0001);
        wait_words(base, HDRS + 10, 200, "short");
        total++;
        if (cap_q[base] !== hdr0w(16'h0, 16'h1234, 16'h000A)) begin
            $display("[TB] FAIL short_hdr0: got=%h want=%h", cap_q[base], hdr0w(16'h0, 16'h1234, 16'h000A));
            bad++;
        end
`ifdef ADC_PACKER_TIMESTAMP_EN
        total++;
        if (cap_q[base+1] !== hdr1w(32'hCAFE0001, 16'h0, 8'h03)) begin
            $display("[TB] FAIL short_hdr1: got=%h want=%h", cap_q[base+1], hdr1w(32'hCAFE0001, 16'h0, 8'h03));
            bad++;
        end
`endif
        for (int j = 0; j < 10; j++) begin
            exp = {(j == 9), 32'h1, 32'(j)};
            total++;
            if (cap_q[base+HDRS+j] !== exp) begin
                $display("[TB] FAIL short_pay%0d: got=%h want=%h", j, cap_q[base+HDRS+j], exp);
                bad++;
            end
        end
        total++;
        if (cyc_q[base+HDRS+9] - cyc_q[base] != HDRS + 9) begin
            $display("[TB] FAIL short_gaps: got=%0d want=%0d", cyc_q[base+HDRS+9] - cyc_q[base], HDRS + 9);
            bad++;
        end
    endtask

    task automatic test_long_burst();
        int base, idx;
        int lens[3] = '{256, 256, 88};
        logic [7:0] flg[3] = '{8'h01, 8'h00, 8'h02};
        logic [64:0] exp;
        do_clear();
        base = cap_q.size();
        drive_burst(600, 32'h2, 16'h0600, 32'h00000600);
        wait_words(base, 3 * HDRS + 600, 2000, "long");
        idx = base;
        for (int f = 0; f < 3; f++) begin
            exp = hdr0w(16'(f), 16'h0600, 16'(lens[f]));
            total++;
            if (cap_q[idx] !== exp) begin
                $display("[TB] FAIL long_hdr0_f%0d: got=%h want=%h", f, cap_q[idx], exp);
                bad++;
            end
            idx++;
`ifdef ADC_PACKER_TIMESTAMP_EN
            exp = hdr1w(32'h00000600, 16'h0, flg[f]);
            total++;
            if (cap_q[idx] !== exp) begin
                $display("[TB] FAIL long_hdr1_f%0d: got=%h want=%h", f, cap_q[idx], exp);
                bad++;
            end
            idx++;
`else
            if (flg[f] == 8'hFF) idx = idx + 0;
`endif
            for (int j = 0; j < lens[f]; j++) begin
                exp = {(j == lens[f] - 1), 32'h2, 32'(f * 256 + j)};
                total++;
                if (cap_q[idx] !== exp) begin
                    $display("[TB] FAIL long_pay_f%0d_w%0d: got=%h want=%h", f, j, cap_q[idx], exp);
                    bad++;
                end
                idx++;
            end
        end
        total++;
        if (cyc_q[base+3*HDRS+599] - cyc_q[base] != 3 * HDRS + 599) begin
            $display("[TB] FAIL long_gaps: got=%0d want=%0d", cyc_q[base+3*HDRS+599] - cyc_q[base], 3 * HDRS + 599);
            bad++;
        end
    endtask

    task automatic test_stall();
        int base, idx, viol0, k;
        int lens[2] = '{256, 44};
        logic [64:0] exp;
        do_clear();
        base  = cap_q.size();
        viol0 = stall_viol;
        k     = 0;
        fork
            drive_burst(300, 32'h3, 16'h0300, 32'h00000300);
            begin
                while (cap_q.size() < base + 2 * HDRS + 300 && k < 3000) begin
                    @(posedge aclk); #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                    k++;
                end
                @(posedge aclk); #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_words(base, 2 * HDRS + 300, 200, "stall");
        total++;
        if (stall_viol != viol0) begin
            $display("[TB] FAIL stall_stable: got=%0d want=%0d", stall_viol - viol0, 0);
            bad++;
        end
        idx = base;
        for (int f = 0; f < 2; f++) begin
            exp = hdr0w(16'(f), 16'h0300, 16'(lens[f]));
            total++;
            if (cap_q[idx] !== exp) begin
                $display("[TB] FAIL stall_hdr0_f%0d: got=%h want=%h", f, cap_q[idx], exp);
                bad++;
            end
            idx = idx + HDRS;
            for (int j = 0; j < lens[f]; j++) begin
                exp = {(j == lens[f] - 1), 32'h3, 32'(f * 256 + j)};
                total++;
                if (cap_q[idx] !== exp) begin
                    $display("[TB] FAIL stall_pay_f%0d_w%0d: got=%h want=%h", f, j, cap_q[idx], exp);
                    bad++;
                end
                idx++;
            end
        end
    endtask

    task automatic test_overflow();
        int base, idx;
        logic [64:0] exp;
        do_clear();
        @(posedge aclk); #1;
        m_axis_tready = 1'b0;
        base = cap_q.size();
        drive_burst(1029, 32'h4, 16'h0404, 32'h00000404);
        repeat (3) @(negedge aclk);
        total++;
        if (drop_count !== 16'd5) begin
            $display("[TB] FAIL ovf_drop_count: got=%0d want=%0d", drop_count, 5);
            bad++;
        end
        total++;
        if (cap_q.size() != base) begin
            $display("[TB] FAIL ovf_no_xfer: got=%0d want=%0d", cap_q.size() - base, 0);
            bad++;
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
        wait_words(base, 4 * (HDRS + 256), 3000, "ovf");
        idx = base;
        for (int f = 0; f < 4; f++) begin
            exp = hdr0w(16'(f), 16'h0404, 16'd256);
            total++;
            if (cap_q[idx] !== exp) begin
                $display("[TB] FAIL ovf_hdr0_f%0d: got=%h want=%h", f, cap_q[idx], exp);
                bad++;
            end
            idx++;
`ifdef ADC_PACKER_TIMESTAMP_EN
            exp = hdr1w(32'h00000404, 16'h0, (f == 0) ? 8'h01 : 8'h00);
            total++;
            if (cap_q[idx] !== exp) begin
                $display("[TB] FAIL ovf_hdr1_f%0d: got=%h want=%h", f, cap_q[idx], exp);
                bad++;
            end
            idx++;
`endif
            for (int j = 0; j < 256; j++) begin
                exp = {(j == 255), 32'h4, 32'(f * 256 + j)};
                total++;
                if (cap_q[idx] !== exp) begin
                    $display("[TB] FAIL ovf_pay_f%0d_w%0d: got=%h want=%h", f, j, cap_q[idx], exp);
                    bad++;
                end
                idx++;
            end
        end
        base = cap_q.size();
        drive_burst(1, 32'h5, 16'h0777, 32'h00000077);
        wait_words(base, HDRS + 1, 100, "ovf_after");
        total++;
        if (cap_q[base] !== hdr0w(16'd4, 16'h0777, 16'd1)) begin
            $display("[TB] FAIL after_hdr0: got=%h want=%h", cap_q[base], hdr0w(16'd4, 16'h0777, 16'd1));
            bad++;
        end
`ifdef ADC_PACKER_TIMESTAMP_EN
        total++;
        if (cap_q[base+1] !== hdr1w(32'h00000077, 16'd5, 8'h07)) begin
            $display("[TB] FAIL after_hdr1: got=%h want=%h", cap_q[base+1], hdr1w(32'h00000077, 16'd5, 8'h07));
            bad++;
        end
`endif
        total++;
        if (cap_q[base+HDRS] !== {1'b1, 32'h5, 32'h0}) begin
            $display("[TB] FAIL after_pay: got=%h want=%h", cap_q[base+HDRS], {1'b1, 32'h5, 32'h0});
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        int base, k;
        logic [64:0] exp;
        do_clear();
        repeat (2) @(negedge aclk);
        total++;
        if (drop_count !== 16'h0) begin
            $display("[TB] FAIL clear_drop: got=%0d want=%0d", drop_count, 0);
            bad++;
        end
        base = cap_q.size();
        drive_burst(10, 32'h6, 16'h0606, 32'h00000606);
        k = 0;
        while (cap_q.size() < base + HDRS + 2 && k < 200) begin
            @(negedge aclk);
            k++;
        end
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            $display("[TB] FAIL midreset_out: got=%h want=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata});
            bad++;
        end
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        base = cap_q.size();
        drive_burst(4, 32'h7, 16'h0044, 32'h00000044);
        wait_words(base, HDRS + 4, 200, "post_reset");
        total++;
        if (cap_q[base] !== hdr0w(16'h0, 16'h0044, 16'd4)) begin
            $display("[TB] FAIL post_reset_hdr0: got=%h want=%h", cap_q[base], hdr0w(16'h0, 16'h0044, 16'd4));
            bad++;
        end
`ifdef ADC_PACKER_TIMESTAMP_EN
        total++;
        if (cap_q[base+1] !== hdr1w(32'h00000044, 16'h0, 8'h03)) begin
            $display("[TB] FAIL post_reset_hdr1: got=%h want=%h", cap_q[base+1], hdr1w(32'h00000044, 16'h0, 8'h03));
            bad++;
        end
`endif
        for (int j = 0; j < 4; j++) begin
            exp = {(j == 3), 32'h7, 32'(j)};
            total++;
            if (cap_q[base+HDRS+j] !== exp) begin
                $display("[TB] FAIL post_reset_pay%0d: got=%h want=%h", j, cap_q[base+HDRS+j], exp);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_burst();
        test_long_burst();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
